// File: rtl/snn_pkg.sv
// Shared definitions for the coincidence-detecting spiking network:
// combiner mode encodings and the saturating membrane adder.
package snn_pkg;

   typedef enum logic {
      MODE_OR  = 1'b0,
      MODE_AND = 1'b1
   } mode_e;

   localparam int ACC_W_DEFAULT = 8;
   localparam int ACC_MAX = (2 ** (ACC_W_DEFAULT - 1)) - 1;
   localparam int ACC_MIN = -(2 ** (ACC_W_DEFAULT - 1));

   // Callers with a non-default accumulator width pass their own limits.
   function automatic int sat_add(input int acc, input int contrib,
                                  input int hi = ACC_MAX, input int lo = ACC_MIN);
      int s;
      s = acc + contrib;
      if (s > hi)
         s = hi;
      else if (s < lo)
         s = lo;
      return s;
   endfunction

endpackage

// File: rtl/snn_lif_neuron.sv
// Leaky integrate-and-fire neuron with signed weight, bipolar threshold
// and a refractory hold-off after each fire.
module snn_lif_neuron
   import snn_pkg::*;
#(
   parameter int W_W     = 4,
   parameter int TH_W    = 4,
   parameter int ACC_W   = 8,
   parameter int REF_CYC = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  spk_in,
   input  logic                  sgn_in,
   input  logic signed [W_W-1:0] w,
   input  logic [TH_W-1:0]       th,
   output logic                  spk,
   output logic                  sgn
);

   localparam int RC_W   = (REF_CYC > 0) ? $clog2(REF_CYC + 1) : 1;
   localparam int ACC_HI = (2 ** (ACC_W - 1)) - 1;
   localparam int ACC_LO = -(2 ** (ACC_W - 1));

   logic signed [ACC_W-1:0] acc, acc_nxt;
   logic [RC_W-1:0]         ref_cnt, ref_nxt;
   logic                    spk_nxt, sgn_nxt;
   int                      contrib, sum, leaked;

   // Firing is judged on the saturated sum; leak only applies when nothing arrived.
   always_comb begin
      acc_nxt = acc;
      ref_nxt = ref_cnt;
      spk_nxt = 1'b0;
      sgn_nxt = 1'b0;
      contrib = 0;
      sum     = 0;
      leaked  = 0;
      if (ref_cnt != '0) begin
         ref_nxt = ref_cnt - RC_W'(1);
         acc_nxt = '0;
      end else begin
         contrib = spk_in ? (sgn_in ? -int'(w) : int'(w)) : 0;
         sum     = sat_add(int'(acc), contrib, ACC_HI, ACC_LO);
         leaked  = sum;
         if (contrib == 0) begin
            if (sum > 0)
               leaked = sum - 1;
            else if (sum < 0)
               leaked = sum + 1;
         end
         if (th != '0 && sum >= int'(th)) begin
            spk_nxt = 1'b1;
            acc_nxt = '0;
            ref_nxt = RC_W'(REF_CYC);
         end else if (th != '0 && sum <= -int'(th)) begin
            spk_nxt = 1'b1;
            sgn_nxt = 1'b1;
            acc_nxt = '0;
            ref_nxt = RC_W'(REF_CYC);
         end else begin
            acc_nxt = ACC_W'(leaked);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         ref_cnt <= '0;
         spk     <= 1'b0;
         sgn     <= 1'b0;
      end else if (en) begin
         acc     <= acc_nxt;
         ref_cnt <= ref_nxt;
         spk     <= spk_nxt;
         sgn     <= sgn_nxt;
      end
   end

endmodule

// File: rtl/snn_coinc_net.sv
// N_IN hidden LIF neurons feeding one output LIF neuron through an
// OR / AND-coincidence combiner built on the registered hidden spikes.
module snn_coinc_net
   import snn_pkg::*;
#(
   parameter int N_IN    = 2,
   parameter int W_W     = 4,
   parameter int TH_W    = 4,
   parameter int ACC_W   = 8,
   parameter int REF_CYC = 2,
   parameter int WIN     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 mode,
   input  logic [N_IN-1:0]      spk_in,
   input  logic [N_IN-1:0]      sgn_in,
   input  logic [N_IN*W_W-1:0]  w_hid,
   input  logic [N_IN*TH_W-1:0] th_hid,
   input  logic [W_W-1:0]       w_out,
   input  logic [TH_W-1:0]      th_out,
   output logic [N_IN-1:0]      spk_hid,
   output logic [N_IN-1:0]      sgn_hid,
   output logic                 spk_out,
   output logic                 sgn_out
);

   localparam int WC_W = $clog2(WIN + 1);

   logic [WC_W-1:0] win_cnt [N_IN];
   logic            prev_mode;
   logic            all_armed, coinc, c_spk, c_sgn;

   for (genvar i = 0; i < N_IN; i++) begin : g_hid
      snn_lif_neuron #(
         .W_W(W_W), .TH_W(TH_W), .ACC_W(ACC_W), .REF_CYC(REF_CYC)
      ) u_lif (
         .clk    (clk),
         .rst    (rst),
         .en     (en),
         .spk_in (spk_in[i]),
         .sgn_in (sgn_in[i]),
         .w      (w_hid[i*W_W +: W_W]),
         .th     (th_hid[i*TH_W +: TH_W]),
         .spk    (spk_hid[i]),
         .sgn    (sgn_hid[i])
      );
   end

   // A channel counts toward a coincidence if it spikes now or its window is still open.
   always_comb begin
      all_armed = 1'b1;
      for (int i = 0; i < N_IN; i++) begin
         if (!spk_hid[i] && win_cnt[i] == '0)
            all_armed = 1'b0;
      end
      coinc = all_armed && (|spk_hid);
      if (mode == MODE_AND) begin
         c_spk = coinc;
         c_sgn = coinc && (|(spk_hid & sgn_hid));
      end else begin
         c_spk = |spk_hid;
         c_sgn = |(spk_hid & sgn_hid);
      end
   end

   // Clearing (coincidence, mode switch, OR mode) beats loading, which beats expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_mode <= MODE_OR;
         for (int i = 0; i < N_IN; i++)
            win_cnt[i] <= '0;
      end else if (en) begin
         prev_mode <= mode;
         for (int i = 0; i < N_IN; i++) begin
            if (mode != prev_mode || mode == MODE_OR || coinc)
               win_cnt[i] <= '0;
            else if (spk_hid[i])
               win_cnt[i] <= WC_W'(WIN);
            else if (win_cnt[i] != '0)
               win_cnt[i] <= win_cnt[i] - WC_W'(1);
         end
      end
   end

   snn_lif_neuron #(
      .W_W(W_W), .TH_W(TH_W), .ACC_W(ACC_W), .REF_CYC(REF_CYC)
   ) u_out (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .spk_in (c_spk),
      .sgn_in (c_sgn),
      .w      (w_out),
      .th     (th_out),
      .spk    (spk_out),
      .sgn    (sgn_out)
   );

endmodule
